// File: rtl/minmax_scan_queue.sv
// minmax_scan_queue
//   Small priority store of DEPTH slots. Each slot holds a payload and an
//   unsigned tag. The block tracks the smallest and largest stored tags, so
//   either extreme can be dequeued. After every removal or replacement the
//   extremes are rebuilt by a DEPTH-cycle sequential scan. When full (and
//   replacement is enabled) a new entry evicts the current maximum, which
//   keeps the DEPTH smallest tags seen. Otherwise the new entry is dropped.
//
// Ports
//   clk_in, rst_in             clock, synchronous active-high reset
//   enq_valid_in/enq_ready_out enqueue handshake, carrying enq_data_in/enq_tag_in
//   deq_valid_in/deq_ready_out dequeue handshake; deq_sel_in 0=min, 1=max
//   data_out, tag_out          last dequeued entry, valid_out pulses one cycle
//   size_out, empty_out,       occupancy
//   full_out
//   min_tag_out, max_tag_out   current extreme tags (all-ones / 0 when empty)
//   drop_out                   one-cycle pulse when an entry is discarded

module minmax_scan_queue #(
    parameter int DATA_WIDTH        = 32,
    parameter int TAG_WIDTH         = 32,
    parameter int DEPTH             = 8,
    parameter int REPLACE_WHEN_FULL = 1
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       enq_valid_in,
    input  logic [DATA_WIDTH-1:0]      enq_data_in,
    input  logic [TAG_WIDTH-1:0]       enq_tag_in,
    output logic                       enq_ready_out,
    input  logic                       deq_valid_in,
    input  logic                       deq_sel_in,
    output logic                       deq_ready_out,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic [TAG_WIDTH-1:0]       tag_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH):0]     size_out,
    output logic                       empty_out,
    output logic                       full_out,
    output logic [TAG_WIDTH-1:0]       min_tag_out,
    output logic [TAG_WIDTH-1:0]       max_tag_out,
    output logic                       drop_out
);

    localparam int   PW      = $clog2(DEPTH);
    localparam int   SW      = PW + 1;
    localparam logic REPLACE = (REPLACE_WHEN_FULL != 0);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state;
    logic [DEPTH-1:0]       slot_valid;
    logic [DATA_WIDTH-1:0]  slot_data [DEPTH];
    logic [TAG_WIDTH-1:0]   slot_tag  [DEPTH];

    logic [TAG_WIDTH-1:0]   min_tag;
    logic [TAG_WIDTH-1:0]   max_tag;
    logic [PW-1:0]          min_ptr;
    logic [PW-1:0]          max_ptr;
    logic [PW-1:0]          scan_idx;
    logic                   scan_seen;

    logic [PW-1:0]          free_idx;
    logic                   free_found;
    logic [PW-1:0]          deq_ptr;
    logic                   enq_fire;
    logic                   deq_fire;

    assign empty_out     = (size_out == '0);
    assign full_out      = (size_out == SW'(DEPTH));
    assign deq_ready_out = (state == IDLE) && !empty_out;
    assign enq_ready_out = (state == IDLE) && !deq_valid_in && (!full_out || REPLACE);
    assign deq_fire      = deq_valid_in && deq_ready_out;
    assign enq_fire      = enq_valid_in && enq_ready_out;
    assign deq_ptr       = deq_sel_in ? max_ptr : min_ptr;

    // The registers hold rebuild values mid-scan; empty always reads as the
    // neutral extremes regardless.
    assign min_tag_out = empty_out ? '1 : min_tag;
    assign max_tag_out = empty_out ? '0 : max_tag;

    // Lowest-index free slot.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!free_found && !slot_valid[i]) begin
                free_idx   = PW'(i);
                free_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            slot_valid <= '0;
            size_out   <= '0;
            min_tag    <= '1;
            max_tag    <= '0;
            min_ptr    <= '0;
            max_ptr    <= '0;
            scan_idx   <= '0;
            scan_seen  <= 1'b0;
            data_out   <= '0;
            tag_out    <= '0;
            valid_out  <= 1'b0;
            drop_out   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            drop_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (deq_fire) begin
                        data_out            <= slot_data[deq_ptr];
                        tag_out             <= slot_tag[deq_ptr];
                        valid_out           <= 1'b1;
                        slot_valid[deq_ptr] <= 1'b0;
                        size_out            <= size_out - SW'(1);
                        state               <= SCAN;
                        scan_idx            <= '0;
                        scan_seen           <= 1'b0;
                        min_tag             <= '1;
                        max_tag             <= '0;
                    end else if (enq_fire) begin
                        if (!full_out) begin
                            slot_data[free_idx]  <= enq_data_in;
                            slot_tag[free_idx]   <= enq_tag_in;
                            slot_valid[free_idx] <= 1'b1;
                            size_out             <= size_out + SW'(1);
                            // First entry defines both extremes; later ones
                            // move a pointer only on a strict improvement.
                            if (empty_out || enq_tag_in < min_tag) begin
                                min_tag <= enq_tag_in;
                                min_ptr <= free_idx;
                            end
                            if (empty_out || enq_tag_in > max_tag) begin
                                max_tag <= enq_tag_in;
                                max_ptr <= free_idx;
                            end
                        end else begin
                            drop_out <= 1'b1;
                            if (enq_tag_in < max_tag) begin
                                slot_data[max_ptr] <= enq_data_in;
                                slot_tag[max_ptr]  <= enq_tag_in;
                                state              <= SCAN;
                                scan_idx           <= '0;
                                scan_seen          <= 1'b0;
                                min_tag            <= '1;
                                max_tag            <= '0;
                            end
                        end
                    end
                end
                SCAN: begin
                    // The first valid slot seeds both extremes so that tags
                    // equal to the neutral values still get a pointer.
                    if (slot_valid[scan_idx]) begin
                        scan_seen <= 1'b1;
                        if (!scan_seen || slot_tag[scan_idx] < min_tag) begin
                            min_tag <= slot_tag[scan_idx];
                            min_ptr <= scan_idx;
                        end
                        if (!scan_seen || slot_tag[scan_idx] > max_tag) begin
                            max_tag <= slot_tag[scan_idx];
                            max_ptr <= scan_idx;
                        end
                    end
                    if (scan_idx == PW'(DEPTH - 1)) begin
                        state <= IDLE;
                    end else begin
                        scan_idx <= scan_idx + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minmax_scan_queue.sv
// tb_minmax_scan_queue
//   Directed bench for minmax_scan_queue with DEPTH=4. dut1 has replacement
//   enabled and dut0 has it disabled. Tags are 8 bits. Every payload is
//   tag+100, which lets the bench tell which entry came out.

module tb_minmax_scan_queue;

    localparam int DW = 16;
    localparam int TW = 8;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // dut1: REPLACE_WHEN_FULL=1
    logic          e1_valid = 1'b0, d1_valid = 1'b0, d1_sel = 1'b0;
    logic [DW-1:0] e1_data = '0;
    logic [TW-1:0] e1_tag = '0;
    logic          e1_ready, d1_ready, v1, full1, empty1, drop1;
    logic [DW-1:0] data1;
    logic [TW-1:0] tag1, min1, max1;
    logic [2:0]    size1;

    // dut0: REPLACE_WHEN_FULL=0
    logic          e0_valid = 1'b0, d0_valid = 1'b0, d0_sel = 1'b0;
    logic [DW-1:0] e0_data = '0;
    logic [TW-1:0] e0_tag = '0;
    logic          e0_ready, d0_ready, v0, full0, empty0, drop0;
    logic [DW-1:0] data0;
    logic [TW-1:0] tag0, min0, max0;
    logic [2:0]    size0;

    minmax_scan_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D), .REPLACE_WHEN_FULL(1)) dut1 (
        .clk_in(clk), .rst_in(rst),
        .enq_valid_in(e1_valid), .enq_data_in(e1_data), .enq_tag_in(e1_tag), .enq_ready_out(e1_ready),
        .deq_valid_in(d1_valid), .deq_sel_in(d1_sel), .deq_ready_out(d1_ready),
        .data_out(data1), .tag_out(tag1), .valid_out(v1),
        .size_out(size1), .empty_out(empty1), .full_out(full1),
        .min_tag_out(min1), .max_tag_out(max1), .drop_out(drop1)
    );

    minmax_scan_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D), .REPLACE_WHEN_FULL(0)) dut0 (
        .clk_in(clk), .rst_in(rst),
        .enq_valid_in(e0_valid), .enq_data_in(e0_data), .enq_tag_in(e0_tag), .enq_ready_out(e0_ready),
        .deq_valid_in(d0_valid), .deq_sel_in(d0_sel), .deq_ready_out(d0_ready),
        .data_out(data0), .tag_out(tag0), .valid_out(v0),
        .size_out(size0), .empty_out(empty0), .full_out(full0),
        .min_tag_out(min0), .max_tag_out(max0), .drop_out(drop0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Single-cycle enqueue on dut1; the caller has already seen ready high.
    task automatic enq1(input logic [TW-1:0] t);
        e1_valid = 1'b1;
        e1_tag   = t;
        e1_data  = DW'(t) + 16'd100;
        step();
        e1_valid = 1'b0;
    endtask

    task automatic enq0(input logic [TW-1:0] t);
        e0_valid = 1'b1;
        e0_tag   = t;
        e0_data  = DW'(t) + 16'd100;
        step();
        e0_valid = 1'b0;
    endtask

    task automatic deq1(input logic sel);
        d1_valid = 1'b1;
        d1_sel   = sel;
        step();
        d1_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (size1 !== 3'd0) begin fails++; $display("FAIL reset_size got=%0d exp=0", size1); end
        tests++; if (empty1 !== 1'b1 || full1 !== 1'b0) begin fails++; $display("FAIL reset_empty_full got=%b%b exp=10", empty1, full1); end
        tests++; if (v1 !== 1'b0 || drop1 !== 1'b0) begin fails++; $display("FAIL reset_pulses got=%b%b exp=00", v1, drop1); end
        tests++; if (data1 !== 16'd0 || tag1 !== 8'd0) begin fails++; $display("FAIL reset_data_tag got=%0d/%0d exp=0/0", data1, tag1); end
        tests++; if (min1 !== 8'hff || max1 !== 8'h00) begin fails++; $display("FAIL reset_extremes got=%h/%h exp=ff/00", min1, max1); end
        tests++; if (e1_ready !== 1'b1 || d1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b%b exp=10", e1_ready, d1_ready); end
    endtask

    task automatic test_enqueue();
        logic [TW-1:0] tags [3];
        tags[0] = 8'd7; tags[1] = 8'd3; tags[2] = 8'd9;
        for (int i = 0; i < 3; i++) begin
            tests++; if (e1_ready !== 1'b1) begin fails++; $display("FAIL enq_ready_%0d got=%b exp=1", i, e1_ready); end
            enq1(tags[i]);
        end
        tests++; if (size1 !== 3'd3) begin fails++; $display("FAIL enq_size got=%0d exp=3", size1); end
        tests++; if (min1 !== 8'd3 || max1 !== 8'd9) begin fails++; $display("FAIL enq_extremes got=%0d/%0d exp=3/9", min1, max1); end
    endtask

    task automatic test_dequeue_min();
        tests++; if (d1_ready !== 1'b1) begin fails++; $display("FAIL deq_ready got=%b exp=1", d1_ready); end
        deq1(1'b0);
        tests++; if (v1 !== 1'b1 || tag1 !== 8'd3 || data1 !== 16'd103) begin fails++; $display("FAIL deq_out got=v%b t%0d d%0d exp=v1 t3 d103", v1, tag1, data1); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (e1_ready !== 1'b0 || d1_ready !== 1'b0) begin fails++; $display("FAIL scan_ready_%0d got=%b%b exp=00", i, e1_ready, d1_ready); end
            step();
            tests++; if (v1 !== 1'b0) begin fails++; $display("FAIL valid_pulse_%0d got=%b exp=0", i, v1); end
        end
        tests++; if (e1_ready !== 1'b1) begin fails++; $display("FAIL post_scan_ready got=%b exp=1", e1_ready); end
        tests++; if (min1 !== 8'd7 || max1 !== 8'd9 || size1 !== 3'd2) begin fails++; $display("FAIL post_scan got=%0d/%0d/%0d exp=7/9/2", min1, max1, size1); end
        tests++; if (tag1 !== 8'd3 || data1 !== 16'd103) begin fails++; $display("FAIL hold_out got=%0d/%0d exp=3/103", tag1, data1); end
    endtask

    task automatic test_replace();
        do_reset();
        enq1(8'd5); enq1(8'd6); enq1(8'd7); enq1(8'd8);
        tests++; if (full1 !== 1'b1 || e1_ready !== 1'b1) begin fails++; $display("FAIL replace_full got=%b%b exp=11", full1, e1_ready); end
        enq1(8'd2);
        tests++; if (drop1 !== 1'b1 || e1_ready !== 1'b0) begin fails++; $display("FAIL replace_drop got=%b%b exp=10", drop1, e1_ready); end
        for (int i = 0; i < 4; i++) step();
        tests++; if (drop1 !== 1'b0) begin fails++; $display("FAIL replace_drop_pulse got=%b exp=0", drop1); end
        tests++; if (min1 !== 8'd2 || max1 !== 8'd7 || size1 !== 3'd4) begin fails++; $display("FAIL replace_scan got=%0d/%0d/%0d exp=2/7/4", min1, max1, size1); end
        deq1(1'b1);
        tests++; if (tag1 !== 8'd7 || data1 !== 16'd107) begin fails++; $display("FAIL replace_evicted got=%0d/%0d exp=7/107", tag1, data1); end
        for (int i = 0; i < 4; i++) step();
        tests++; if (max1 !== 8'd6 || min1 !== 8'd2) begin fails++; $display("FAIL replace_rescan got=%0d/%0d exp=2/6", min1, max1); end
    endtask

    task automatic test_discard();
        do_reset();
        enq1(8'd2); enq1(8'd5); enq1(8'd6); enq1(8'd7);
        enq1(8'd9);
        tests++; if (drop1 !== 1'b1) begin fails++; $display("FAIL discard_drop got=%b exp=1", drop1); end
        tests++; if (e1_ready !== 1'b1 || d1_ready !== 1'b1) begin fails++; $display("FAIL discard_no_scan got=%b%b exp=11", e1_ready, d1_ready); end
        tests++; if (min1 !== 8'd2 || max1 !== 8'd7 || size1 !== 3'd4) begin fails++; $display("FAIL discard_extremes got=%0d/%0d/%0d exp=2/7/4", min1, max1, size1); end
        step();
        tests++; if (drop1 !== 1'b0) begin fails++; $display("FAIL discard_pulse got=%b exp=0", drop1); end
        deq1(1'b1);
        tests++; if (tag1 !== 8'd7 || data1 !== 16'd107) begin fails++; $display("FAIL discard_contents got=%0d/%0d exp=7/107", tag1, data1); end
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_no_replace();
        do_reset();
        enq0(8'd4); enq0(8'd2);
        e0_valid = 1'b1; e0_tag = 8'd1; e0_data = 16'd101;
        d0_valid = 1'b1; d0_sel = 1'b0;
        #1;
        tests++; if (e0_ready !== 1'b0 || d0_ready !== 1'b1) begin fails++; $display("FAIL simul_ready got=%b%b exp=01", e0_ready, d0_ready); end
        step();
        e0_valid = 1'b0; d0_valid = 1'b0;
        tests++; if (v0 !== 1'b1 || tag0 !== 8'd2 || size0 !== 3'd1) begin fails++; $display("FAIL simul_deq got=v%b t%0d s%0d exp=v1 t2 s1", v0, tag0, size0); end
        for (int i = 0; i < 4; i++) step();
        tests++; if (min0 !== 8'd4 || max0 !== 8'd4) begin fails++; $display("FAIL simul_scan got=%0d/%0d exp=4/4", min0, max0); end
        enq0(8'd1); enq0(8'd3); enq0(8'd5);
        tests++; if (full0 !== 1'b1 || e0_ready !== 1'b0) begin fails++; $display("FAIL noreplace_full got=%b%b exp=10", full0, e0_ready); end
        e0_valid = 1'b1; e0_tag = 8'd0; e0_data = 16'd100;
        step();
        e0_valid = 1'b0;
        tests++; if (size0 !== 3'd4 || drop0 !== 1'b0 || min0 !== 8'd1 || max0 !== 8'd5) begin fails++; $display("FAIL noreplace_hold got=s%0d d%b %0d/%0d exp=s4 d0 1/5", size0, drop0, min0, max0); end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        enq1(8'd7); enq1(8'd3);
        deq1(1'b1);
        step();
        rst = 1'b1;
        step();
        tests++; if (v1 !== 1'b0 || drop1 !== 1'b0 || size1 !== 3'd0 || empty1 !== 1'b1 || full1 !== 1'b0) begin fails++; $display("FAIL midscan_state got=v%b d%b s%0d e%b f%b exp=v0 d0 s0 e1 f0", v1, drop1, size1, empty1, full1); end
        tests++; if (data1 !== 16'd0 || tag1 !== 8'd0 || min1 !== 8'hff || max1 !== 8'h00) begin fails++; $display("FAIL midscan_values got=%0d/%0d %h/%h exp=0/0 ff/00", data1, tag1, min1, max1); end
        rst = 1'b0;
        #1;
        tests++; if (e1_ready !== 1'b1) begin fails++; $display("FAIL midscan_ready got=%b exp=1", e1_ready); end
        step();
        tests++; if (v1 !== 1'b0 || drop1 !== 1'b0 || e1_ready !== 1'b1) begin fails++; $display("FAIL midscan_after got=%b%b%b exp=001", v1, drop1, e1_ready); end
    endtask

    initial begin
        test_reset();
        test_enqueue();
        test_dequeue_min();
        test_replace();
        test_discard();
        test_no_replace();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/minmax_scan_queue.md
MINMAX_SCAN_QUEUE -- requirements
Module: minmax_scan_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width.
REQ-002 SHALL have parameter TAG_WIDTH, default 32, unsigned priority tag width.
REQ-003 SHALL have parameter DEPTH, default 8, slot count (power of two, >=2).
REQ-004 SHALL have parameter REPLACE_WHEN_FULL, default 1, enabling keep-DEPTH-smallest insertion when full.
REQ-005 SHALL have port clk_in, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have ports enq_valid_in (in, 1), enq_data_in (in, DATA_WIDTH), enq_tag_in (in, TAG_WIDTH), enq_ready_out (out, 1): enqueue handshake.
REQ-008 SHALL have ports deq_valid_in (in, 1), deq_sel_in (in, 1; 0=smallest tag, 1=largest tag), deq_ready_out (out, 1): dequeue handshake.
REQ-009 SHALL have outputs data_out (DATA_WIDTH), tag_out (TAG_WIDTH), valid_out (1): dequeued entry.
REQ-010 SHALL have outputs size_out ($clog2(DEPTH)+1), empty_out (1), full_out (1): occupancy.
REQ-011 SHALL have outputs min_tag_out, max_tag_out (TAG_WIDTH each): current extreme tags.
REQ-012 SHALL have output drop_out (1): one-cycle pulse when an entry is discarded by replacement.

Function
REQ-013 SHALL implement FSM states IDLE and SCAN; transfer occurs when valid and ready are both high at a rising edge.
REQ-014 SHALL drive deq_ready_out = IDLE and not empty_out.
REQ-015 SHALL drive enq_ready_out = IDLE and not deq_valid_in and (not full_out or REPLACE_WHEN_FULL=1); dequeue wins simultaneous requests.
REQ-016 SHALL store an accepted enqueue, when not full, into the lowest-index free slot; size_out +1.
REQ-017 SHALL update min/max registers and their slot pointers on enqueue in the same edge, strict compare (ties keep existing pointer).
REQ-018 SHALL, when full and REPLACE_WHEN_FULL=1, with enq_tag_in < max_tag_out, overwrite the max slot, pulse drop_out next cycle, then enter SCAN.
REQ-019 SHALL, when full and REPLACE_WHEN_FULL=1, with enq_tag_in >= max_tag_out, discard the input, pulse drop_out next cycle, leave contents unchanged, stay IDLE.
REQ-020 SHALL, on accepted dequeue, register the selected slot to data_out/tag_out, assert valid_out for exactly the next cycle, invalidate the slot, size_out -1, enter SCAN.
REQ-021 SHALL in SCAN reset min to all-ones and max to 0, then examine one slot per cycle, index 0 to DEPTH-1, strict compare, so ties resolve to the lowest index.
REQ-022 SHALL remain in SCAN exactly DEPTH cycles, then return to IDLE with min/max tags and pointers valid; both ready outputs low throughout.
REQ-023 SHALL ignore enq_valid_in and deq_valid_in during SCAN; requesters hold until ready.
REQ-024 SHALL present min_tag_out all-ones and max_tag_out 0 whenever empty.
REQ-025 SHALL drive empty_out = (size_out==0), full_out = (size_out==DEPTH), consistent with slot state every cycle.
REQ-026 SHALL hold data_out/tag_out at last dequeued values when valid_out low.

Reset
REQ-027 SHALL on rst_in clear all slot valid bits, size_out 0, empty_out 1, full_out 0, valid_out 0, drop_out 0, data_out 0, tag_out 0, min_tag_out all-ones, max_tag_out 0, state IDLE.
REQ-028 SHALL abort any SCAN in progress on reset; no valid_out or drop_out pulse after the reset edge.
REQ-029 SHALL have enq_ready_out high in the first cycle after reset is released.

Verification (DEPTH=4, REPLACE_WHEN_FULL=1 unless stated)
REQ-030 SHALL cover: enqueue tags 7,3,9 -> size_out 3, min_tag_out 3, max_tag_out 9 one cycle after last enqueue, ready never drops.
REQ-031 SHALL cover: then dequeue smallest -> tag_out 3, valid_out one cycle; ready low 4 cycles; afterwards min 7, max 9, size 2.
REQ-032 SHALL cover: fill with 5,6,7,8, enqueue 2 -> drop_out pulse, 8 evicted, SCAN, then min 2, max 7, size 4.
REQ-033 SHALL cover: full 2,5,6,7, enqueue 9 -> drop_out pulse, contents and extremes unchanged, no SCAN.
REQ-034 SHALL cover: REPLACE_WHEN_FULL=0, full -> enq_ready_out 0; simultaneous enq/deq in IDLE -> only dequeue accepted.
REQ-035 SHALL cover: rst_in asserted mid-SCAN -> all outputs at reset values next cycle, empty_out 1, enq_ready_out 1 after release.
